// File: rtl/instr_prefetch.sv
// instr_prefetch: instruction prefetch stage between a synchronous instruction ROM
// and the fetch/decode input of the pipeline.
// It owns the fetch PC and keeps up to DEPTH fetched words queued.
// It presents the words in order using a valid/stall handshake.
// A flush discards every queued and in-flight word and restarts fetching at flushPc.
// Optional feature macro: PREFETCH_BYPASS_EN. When defined, a word that returns
// while the queue is empty is presented in the same cycle it arrives.
module instr_prefetch #(
   parameter int DEPTH = 4,
   parameter int AW    = 12,
   parameter int DW    = 32
) (
   input  logic                       clk,
   input  logic                       nRst,
   output logic [AW-1:0]              memAddr,
   output logic                       memRe,
   input  logic [DW-1:0]              memData,
   input  logic                       flush,
   input  logic [AW-1:0]              flushPc,
   output logic [DW-1:0]              instrOut,
   output logic [AW-1:0]              instrPc,
   output logic                       instrValid,
   input  logic                       stall,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CW:0]   OCC_FULL = (CW+1)'(DEPTH);

   typedef struct packed {
      logic [DW-1:0] instr;
      logic [AW-1:0] pc;
   } entry_t;

   entry_t          queue [DEPTH];
   logic [PW-1:0]   rdPtr;
   logic [PW-1:0]   wrPtr;
   logic [CW-1:0]   cnt;
   logic [AW-1:0]   fetchPc;
   logic            inflight;
   logic [AW-1:0]   inflightPc;

   logic            headValid;
   logic            bypassHit;
   logic            consume;
   logic            popQueue;
   logic            doPush;
   logic [CW:0]     occupancy;

   // Handshake, credit and output selection. Everything here is derived from
   // registered state plus the current flush, stall and memData inputs.
   always_comb begin
      // NOTE: every output of this block gets a default value first. A path
      // that skipped an assignment would otherwise infer a latch.
      bypassHit  = 1'b0;
      instrOut   = '0;
      instrPc    = '0;
      headValid  = (cnt != '0);
`ifdef PREFETCH_BYPASS_EN
      bypassHit  = !headValid && inflight && !flush;
`endif
      instrValid = !nRst && !flush && (headValid || bypassHit);
      if (instrValid) begin
         if (headValid) begin
            instrOut = queue[rdPtr].instr;
            instrPc  = queue[rdPtr].pc;
         end else begin
            instrOut = memData;
            instrPc  = inflightPc;
         end
      end
      consume   = instrValid && !stall;
      popQueue  = consume && headValid;
      // A bypassed word that is consumed right away never enters the queue.
      doPush    = inflight && !flush && !(bypassHit && !stall);
      // A word that is consumed this cycle frees its slot for a new read.
      occupancy = {1'b0, cnt} + (CW+1)'(inflight);
      memRe     = !nRst && !flush && ((occupancy < OCC_FULL) || consume);
   end

   assign memAddr = fetchPc;
   assign count   = cnt;

   // State update for the fetch PC, the in-flight tracking, the queue pointers and the occupancy.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments. Every register
      // then samples the values from before the edge, whatever order the
      // statements appear in.
      if (nRst) begin
         fetchPc    <= '0;
         inflight   <= 1'b0;
         inflightPc <= '0;
         rdPtr      <= '0;
         wrPtr      <= '0;
         cnt        <= '0;
      end else if (flush) begin
         fetchPc    <= flushPc;
         inflight   <= 1'b0;
         rdPtr      <= '0;
         wrPtr      <= '0;
         cnt        <= '0;
      end else begin
         inflight <= memRe;
         if (memRe) begin
            fetchPc    <= fetchPc + AW'(1);
            inflightPc <= fetchPc;
         end
         if (doPush) wrPtr <= wrPtr + PTR_ONE;
         if (popQueue) rdPtr <= rdPtr + PTR_ONE;
         cnt <= cnt + CW'(doPush) - CW'(popQueue);
      end
   end

   // Queue storage. An entry is written when a returning word is pushed.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset. cnt alone decides which entries
      // are live, so stale contents are never presented.
      if (!nRst && doPush) queue[wrPtr] <= '{instr: memData, pc: inflightPc};
   end

endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: self-checking bench for instr_prefetch.
// It models the ROM as ROM[a] = a + 0x100.
// The reference model works at the level of the instruction stream. Every
// accepted word must carry the next expected PC, and that PC restarts at
// flushPc after a redirect.
module tb_instr_prefetch;

   localparam int DEPTH = 4;
   localparam int AW    = 12;
   localparam int DW    = 32;
`ifdef PREFETCH_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic            clk = 1'b0;
   logic            nRst;
   logic [AW-1:0]   memAddr;
   logic            memRe;
   logic [DW-1:0]   memData;
   logic            flush;
   logic [AW-1:0]   flushPc;
   logic [DW-1:0]   instrOut;
   logic [AW-1:0]   instrPc;
   logic            instrValid;
   logic            stall;
   logic [2:0]      count;

   int total = 0;
   int bad   = 0;
   logic [AW-1:0] expPc;

   instr_prefetch #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .nRst(nRst), .memAddr(memAddr), .memRe(memRe), .memData(memData),
      .flush(flush), .flushPc(flushPc), .instrOut(instrOut), .instrPc(instrPc),
      .instrValid(instrValid), .stall(stall), .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] romWord(input logic [AW-1:0] a);
      return 32'h100 + {20'b0, a};
   endfunction

   // Synchronous ROM. Data is meaningful only in the cycle after a read.
   always @(posedge clk) memData <= memRe ? romWord(memAddr) : 32'hDEADBEEF;

   task automatic toNeg();
      @(negedge clk);
   endtask

   task automatic toPos();
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      nRst = 1'b1; flush = 1'b0; stall = 1'b0; flushPc = '0;
      repeat (2) toPos();
   endtask

   // Accept the current head and compare it with the reference stream.
   task automatic acceptWord(input string name);
      total++;
      if (instrPc !== expPc || instrOut !== romWord(expPc)) begin
         bad++;
         $display("FAIL %s pc=%h instr=%h want pc=%h instr=%h", name, instrPc, instrOut,
                  expPc, romWord(expPc));
      end
      expPc = expPc + 12'd1;
   endtask

   task automatic test_reset();
      applyReset();
      toNeg();
      total++;
      if (memRe !== 1'b0 || memAddr !== '0) begin
         bad++; $display("FAIL reset_mem memRe=%b memAddr=%h want 0 0", memRe, memAddr);
      end
      total++;
      if (instrValid !== 1'b0 || instrOut !== '0 || instrPc !== '0 || count !== '0) begin
         bad++;
         $display("FAIL reset_out valid=%b instr=%h pc=%h count=%0d want all 0",
                  instrValid, instrOut, instrPc, count);
      end
      toPos();
      nRst = 1'b0;
   endtask

   task automatic test_free_run();
      int firstValid = -1;
      int accepted = 0;
      expPc = '0;
      for (int cyc = 0; cyc < 25; cyc++) begin
         toNeg();
         if (cyc == 0) begin
            total++;
            if (memRe !== 1'b1 || memAddr !== 12'h000) begin
               bad++; $display("FAIL first_issue memRe=%b memAddr=%h want 1 000", memRe, memAddr);
            end
         end
         if (instrValid) begin
            if (firstValid < 0) firstValid = cyc;
            acceptWord("free_run");
            accepted++;
         end
         total++;
         if (count > 3'd1) begin
            bad++; $display("FAIL free_run_count count=%0d want <=1", count);
         end
         toPos();
      end
      total++;
      if (firstValid != LAT) begin
         bad++; $display("FAIL free_run_latency got=%0d want=%0d", firstValid, LAT);
      end
      total++;
      if (accepted != 25 - LAT) begin
         bad++; $display("FAIL free_run_rate got=%0d want=%0d", accepted, 25 - LAT);
      end
   endtask

   // Reset, release, and accept the very first word (pc 0) with stall low.
   task automatic startAndTakeFirst(input string name);
      bit found = 0;
      applyReset();
      nRst = 1'b0;
      expPc = '0;
      for (int cyc = 0; cyc < 8 && !found; cyc++) begin
         toNeg();
         if (instrValid) begin
            found = 1;
            acceptWord(name);
         end
         toPos();
      end
      if (!found) begin
         total++; bad++; $display("FAIL %s_first_valid got=none want=valid", name);
      end
   endtask

   task automatic test_stall();
      int accepted = 0;
      startAndTakeFirst("stall");
      stall = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         toNeg();
         if (cyc == 9) begin
            total++;
            if (count !== 3'(DEPTH) || memRe !== 1'b0) begin
               bad++; $display("FAIL stall_full count=%0d memRe=%b want %0d 0", count, memRe, DEPTH);
            end
            total++;
            if (memAddr !== 12'(DEPTH + 1) || instrPc !== 12'h001 || instrValid !== 1'b1) begin
               bad++;
               $display("FAIL stall_hold memAddr=%h pc=%h valid=%b want %h 001 1",
                        memAddr, instrPc, instrValid, 12'(DEPTH + 1));
            end
         end
         toPos();
      end
      stall = 1'b0;
      toNeg();
      total++;
      if (memRe !== 1'b1 || memAddr !== 12'(DEPTH + 1)) begin
         bad++; $display("FAIL stall_release_credit memRe=%b memAddr=%h want 1 %h", memRe, memAddr,
                         12'(DEPTH + 1));
      end
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (cyc != 0) toNeg();
         if (instrValid) begin
            acceptWord("stall_release");
            accepted++;
         end
         toPos();
      end
      total++;
      if (accepted != 12) begin
         bad++; $display("FAIL stall_release_rate got=%0d want=12", accepted);
      end
   endtask

   task automatic test_flush();
      bit armed = 0;
      int firstValid = -1;
      startAndTakeFirst("flush_pre");
      stall = 1'b1;
      for (int cyc = 0; cyc < 10 && !armed; cyc++) begin
         toNeg();
         if (count == 3'd2) armed = 1;
         toPos();
      end
      flush = 1'b1; flushPc = 12'h7F0;
      toNeg();
      total++;
      if (count !== 3'd3 || memRe !== 1'b0 || instrValid !== 1'b0) begin
         bad++; $display("FAIL flush_cycle count=%0d memRe=%b valid=%b want 3 0 0",
                         count, memRe, instrValid);
      end
      toPos();
      flush = 1'b0; stall = 1'b0;
      expPc = 12'h7F0;
      for (int k = 1; k <= 10; k++) begin
         toNeg();
         if (k == 1) begin
            total++;
            if (memRe !== 1'b1 || memAddr !== 12'h7F0) begin
               bad++; $display("FAIL flush_reissue memRe=%b memAddr=%h want 1 7f0", memRe, memAddr);
            end
         end
         if (instrValid) begin
            if (firstValid < 0) firstValid = k;
            acceptWord("flush_stream");
         end
         toPos();
      end
      total++;
      if (firstValid != LAT + 1) begin
         bad++; $display("FAIL flush_latency got=F+%0d want=F+%0d", firstValid, LAT + 1);
      end
   endtask

   task automatic test_wrap();
      int accepted = 0;
      flush = 1'b1; flushPc = 12'hFFE; stall = 1'b0;
      toNeg();
      toPos();
      flush = 1'b0;
      expPc = 12'hFFE;
      for (int k = 0; k < 8; k++) begin
         toNeg();
         if (instrValid) begin
            acceptWord("wrap");
            accepted++;
         end
         toPos();
      end
      total++;
      if (accepted < 4) begin
         bad++; $display("FAIL wrap_count got=%0d want>=4", accepted);
      end
   endtask

   task automatic test_flush_stall_reset();
      bit full = 0;
      stall = 1'b1;
      for (int cyc = 0; cyc < 12 && !full; cyc++) begin
         toNeg();
         if (count == 3'(DEPTH)) full = 1;
         toPos();
      end
      total++;
      if (!full) begin
         bad++; $display("FAIL fsr_fill got=not_full want=full");
      end
      flush = 1'b1; flushPc = 12'h123;
      toNeg();
      total++;
      if (instrValid !== 1'b0 || memRe !== 1'b0) begin
         bad++; $display("FAIL fsr_flush valid=%b memRe=%b want 0 0", instrValid, memRe);
      end
      toPos();
      flush = 1'b0;
      toNeg();
      total++;
      if (count !== '0 || instrValid !== 1'b0 || memAddr !== 12'h123) begin
         bad++; $display("FAIL fsr_cleared count=%0d valid=%b memAddr=%h want 0 0 123",
                         count, instrValid, memAddr);
      end
      toPos();
      stall = 1'b0;
      repeat (5) toPos();
      nRst = 1'b1;
      toNeg();
      total++;
      if (memRe !== 1'b0 || instrValid !== 1'b0) begin
         bad++; $display("FAIL fsr_in_reset memRe=%b valid=%b want 0 0", memRe, instrValid);
      end
      toPos();
      nRst = 1'b0;
      toNeg();
      total++;
      if (count !== '0 || instrValid !== 1'b0 || instrOut !== '0 || instrPc !== '0) begin
         bad++; $display("FAIL fsr_after_reset count=%0d valid=%b instr=%h pc=%h want all 0",
                         count, instrValid, instrOut, instrPc);
      end
      total++;
      if (memRe !== 1'b1 || memAddr !== '0) begin
         bad++; $display("FAIL fsr_restart memRe=%b memAddr=%h want 1 000", memRe, memAddr);
      end
      toPos();
   endtask

   task automatic test_random();
      int accepted = 0;
      logic [AW-1:0] target;
      applyReset();
      nRst = 1'b0;
      expPc = '0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         stall = ($urandom_range(0, 99) < 40);
         flush = ($urandom_range(0, 99) < 3);
         target = AW'($urandom);
         flushPc = target;
         toNeg();
         if (flush) begin
            total++;
            if (instrValid !== 1'b0 || memRe !== 1'b0) begin
               bad++; $display("FAIL rand_flush valid=%b memRe=%b want 0 0", instrValid, memRe);
            end
         end else if (instrValid && !stall) begin
            acceptWord("rand_stream");
            accepted++;
         end
         if (!instrValid) begin
            total++;
            if (instrOut !== '0 || instrPc !== '0) begin
               bad++; $display("FAIL rand_nop instr=%h pc=%h want 0 0", instrOut, instrPc);
            end
         end
         total++;
         if (count > 3'(DEPTH)) begin
            bad++; $display("FAIL rand_count count=%0d want<=%0d", count, DEPTH);
         end
         toPos();
         if (flush) expPc = target;
      end
      flush = 1'b0; stall = 1'b0;
      total++;
      if (accepted < 300) begin
         bad++; $display("FAIL rand_throughput got=%0d want>=300", accepted);
      end
   endtask

   initial begin
      nRst = 1'b1; flush = 1'b0; stall = 1'b0; flushPc = '0;
      test_reset();
      test_free_run();
      test_stall();
      test_flush();
      test_wrap();
      test_flush_stall_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
